// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and word-memory bus bundle for mem_access_unit
//
// Purpose: groups the pipeline request/response handshake and the word-memory
// port so they travel as one port on mem_access_unit.
// Ports (signals):
//   req_valid/req_we/req_size/req_signed/req_addr/req_wdata : pipeline request
//   req_ready/busy                                          : accept / stall
//   resp_valid/resp_err/resp_rdata                          : completion pulse
//   mem_WE/mem_RE/mem_A/mem_WD/mem_RD                       : word memory port
// Modports: master = pipeline plus memory side, slave = the access unit.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        busy;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_WE;
    logic        mem_RE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_RD,
        input  req_ready, busy, resp_valid, resp_err, resp_rdata,
               mem_WE, mem_RE, mem_A, mem_WD
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_RD,
        output req_ready, busy, resp_valid, resp_err, resp_rdata,
               mem_WE, mem_RE, mem_A, mem_WD
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between a pipeline and a word-wide memory
//
// Purpose: accepts one byte/half/word load or store at a time, checks
// alignment, performs read-modify-write for sub-word stores and returns a
// one-cycle response pulse with sign/zero-extended load data.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_access_unit_if.slave (request, response and memory signals)
module mem_access_unit (
    input logic              clk,
    input logic              rst,
    mem_access_unit_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD      = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] WR      = 2'd3;

    logic [1:0]  state;
    logic        lat_we;
    logic        lat_signed;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] wbuf;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        req_bad;
    logic [15:0] lane16;
    logic [7:0]  lane8;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        req_bad = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    end

    // Select the addressed lane of the returned word, then extend it.
    always_comb begin
        lane16 = lat_addr[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];
        lane8  = lat_addr[0] ? lane16[15:8] : lane16[7:0];
        case (lat_size)
            2'b00:   load_val = {{24{lat_signed & lane8[7]}}, lane8};
            2'b01:   load_val = {{16{lat_signed & lane16[15]}}, lane16};
            default: load_val = bus.mem_RD;
        endcase
    end

    // Sub-word store: overlay the right-justified store data on the read word.
    always_comb begin
        merged = bus.mem_RD;
        if (lat_size == 2'b00) begin
            case (lat_addr[1:0])
                2'd0:    merged[7:0]   = lat_wdata[7:0];
                2'd1:    merged[15:8]  = lat_wdata[7:0];
                2'd2:    merged[23:16] = lat_wdata[7:0];
                default: merged[31:24] = lat_wdata[7:0];
            endcase
        end else if (lat_size == 2'b01) begin
            if (lat_addr[1]) merged[31:16] = lat_wdata[15:0];
            else             merged[15:0]  = lat_wdata[15:0];
        end else begin
            merged = lat_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lat_we       <= 1'b0;
            lat_signed   <= 1'b0;
            lat_size     <= 2'b00;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            wbuf         <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (req_bad) begin
                            // Rejected requests never leave IDLE or touch memory.
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            lat_we     <= bus.req_we;
                            lat_signed <= bus.req_signed;
                            lat_size   <= bus.req_size;
                            lat_addr   <= bus.req_addr;
                            lat_wdata  <= bus.req_wdata;
                            wbuf       <= bus.req_wdata;
                            state      <= (bus.req_we && bus.req_size == 2'b10) ? WR : RD;
                        end
                    end
                end
                RD: state <= RD_WAIT;
                RD_WAIT: begin
                    if (lat_we) begin
                        wbuf  <= merged;
                        state <= WR;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_val;
                        state        <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'd0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    // Strobes are gated by rst so a reset edge can never commit a write.
    assign bus.mem_RE     = (state == RD) && !rst;
    assign bus.mem_WE     = (state == WR) && !rst;
    assign bus.mem_A      = (state != IDLE) ? {lat_addr[31:2], 2'b00} : 32'd0;
    assign bus.mem_WD     = (state == WR) ? wbuf : 32'd0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          we_n;
        int          re_n;
        logic [31:0] wd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus();
    mem_access_unit dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [0:63];
    logic [31:0] rd_q = 32'd0;
    always @(posedge clk) begin
        if (bus.mem_WE)      mem[bus.mem_A[7:2]] <= bus.mem_WD;
        else if (bus.mem_RE) rd_q <= mem[bus.mem_A[7:2]];
    end
    assign bus.mem_RD = rd_q;

    int we_cnt = 0, re_cnt = 0, resp_cnt = 0, both_cnt = 0, busy_bad = 0;
    logic [31:0] last_wa = 32'd0, last_wd = 32'd0, last_ra = 32'd0;
    always @(negedge clk) begin
        if (bus.mem_WE) begin
            we_cnt++;
            last_wa = bus.mem_A;
            last_wd = bus.mem_WD;
        end
        if (bus.mem_RE) begin
            re_cnt++;
            last_ra = bus.mem_A;
        end
        if (bus.mem_WE && bus.mem_RE) both_cnt++;
        if (bus.busy !== ~bus.req_ready) busy_bad++;
        if (bus.resp_valid) resp_cnt++;
    end

    int pass_cnt = 0, total_cnt = 0, exp_resp = 0;
    vec_t sb[$];
    vec_t vecs[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic err, input logic [31:0] rdata, input int lat,
                                input int we_n, input int re_n, input logic [31:0] wd);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.err = err; v.rdata = rdata; v.lat = lat; v.we_n = we_n; v.re_n = re_n; v.wd = wd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_size   = v.size;
        bus.req_signed = v.sgn;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
    endtask

    // Drive at the falling edge; since the previous call returns inside its
    // response cycle, every request is issued back-to-back with that response.
    task automatic run_vec(input vec_t v, input string tag);
        int   lat, we0, re0;
        vec_t e;
        @(negedge clk);
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        drive(v);
        sb.push_back(v);
        exp_resp++;
        we0 = we_cnt;
        re0 = re_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        check({tag, " timeout"}, 32'(bus.resp_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " err"}, 32'(bus.resp_err), 32'(e.err));
        check({tag, " rdata"}, bus.resp_rdata, e.rdata);
        check({tag, " we_cycles"}, 32'(we_cnt - we0), 32'(e.we_n));
        check({tag, " re_cycles"}, 32'(re_cnt - re0), 32'(e.re_n));
        if (e.we_n > 0) begin
            check({tag, " mem_A wr"}, last_wa, {e.addr[31:2], 2'b00});
            check({tag, " mem_WD"}, last_wd, e.wd);
        end
        if (e.re_n > 0) check({tag, " mem_A rd"}, last_ra, {e.addr[31:2], 2'b00});
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, " busy"}, 32'(bus.busy), 32'd0);
        check({tag, " mem_WE"}, 32'(bus.mem_WE), 32'd0);
        check({tag, " mem_RE"}, 32'(bus.mem_RE), 32'd0);
        check({tag, " mem_A"}, bus.mem_A, 32'd0);
        check({tag, " mem_WD"}, bus.mem_WD, 32'd0);
        check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
        check({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
    endtask

    // Byte store abandoned by a reset raised after 'hold' cycles in flight.
    task automatic abort_store(input int hold, input string tag);
        int          we0, r0;
        logic [31:0] word0;
        @(negedge clk);
        drive(mk(1'b1, 2'b00, 1'b0, 32'h20, 32'h55, 1'b0, 32'd0, 0, 0, 0, 32'd0));
        word0 = mem[8];
        we0 = we_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        r0 = resp_cnt;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        check({tag, " busy before reset"}, 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_outputs(tag);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check({tag, " no write"}, 32'(we_cnt - we0), 32'd0);
        check({tag, " no resp"}, 32'(resp_cnt - r0), 32'd0);
        check({tag, " word kept"}, mem[8], word0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //           we    size   sgn   addr       wdata         err   rdata          lat we re wd
        vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0,         1, 1, 0, 32'h11223344);
        vecs[1]  = mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,         1, 1, 0, 32'hDEADBEEF);
        vecs[2]  = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF,  2, 0, 1, 32'h0);
        vecs[3]  = mk(1'b0, 2'b00, 1'b1, 32'h23, 32'h0,        1'b0, 32'h00000011,  2, 0, 1, 32'h0);
        vecs[4]  = mk(1'b0, 2'b00, 1'b1, 32'h21, 32'h0,        1'b0, 32'h00000033,  2, 0, 1, 32'h0);
        vecs[5]  = mk(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000F0, 1'b0, 32'h0,         3, 1, 1, 32'h1122F044);
        vecs[6]  = mk(1'b0, 2'b00, 1'b1, 32'h21, 32'h0,        1'b0, 32'hFFFFFFF0,  2, 0, 1, 32'h0);
        vecs[7]  = mk(1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        1'b0, 32'h000000F0,  2, 0, 1, 32'h0);
        vecs[8]  = mk(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0,         1, 1, 0, 32'h11223344);
        vecs[9]  = mk(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFFFFAB, 1'b0, 32'h0,         3, 1, 1, 32'h11AB3344);
        vecs[10] = mk(1'b1, 2'b01, 1'b0, 32'h20, 32'h1234BEEF, 1'b0, 32'h0,         3, 1, 1, 32'h11ABBEEF);
        vecs[11] = mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        1'b0, 32'h11ABBEEF,  2, 0, 1, 32'h0);
        vecs[12] = mk(1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        1'b1, 32'h0,         0, 0, 0, 32'h0);
        vecs[13] = mk(1'b0, 2'b11, 1'b0, 32'h20, 32'h0,        1'b1, 32'h0,         0, 0, 0, 32'h0);
        vecs[14] = mk(1'b0, 2'b01, 1'b1, 32'h21, 32'h0,        1'b1, 32'h0,         0, 0, 0, 32'h0);
        vecs[15] = mk(1'b1, 2'b01, 1'b0, 32'h23, 32'hFFFF,     1'b1, 32'h0,         0, 0, 0, 32'h0);
        vecs[16] = mk(1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        1'b0, 32'h000011AB,  2, 0, 1, 32'h0);
        vecs[17] = mk(1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        1'b0, 32'hFFFFBEEF,  2, 0, 1, 32'h0);
        vecs[18] = mk(1'b0, 2'b01, 1'b0, 32'h20, 32'h0,        1'b0, 32'h0000BEEF,  2, 0, 1, 32'h0);
        vecs[19] = mk(1'b1, 2'b00, 1'b0, 32'h23, 32'h00000080, 1'b0, 32'h0,         3, 1, 1, 32'h80ABBEEF);
        vecs[20] = mk(1'b0, 2'b00, 1'b1, 32'h23, 32'h0,        1'b0, 32'hFFFFFF80,  2, 0, 1, 32'h0);
        vecs[21] = mk(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 1'b1, 32'h0,         0, 0, 0, 32'h0);
        vecs[22] = mk(1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF,  2, 0, 1, 32'h0);

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_outputs("por");

        for (int i = 0; i < 23; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        abort_store(1, "rst_rdwait");
        abort_store(2, "rst_wr");
        run_vec(mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h80ABBEEF, 2, 0, 1, 32'h0),
                "post_reset_load");

        repeat (2) @(posedge clk);
        #1;
        check("we_and_re_together", 32'(both_cnt), 32'd0);
        check("busy_vs_ready", 32'(busy_bad), 32'd0);
        check("resp_pulse_count", 32'(resp_cnt), 32'(exp_resp));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
